// File: rtl/delay_timer_pkg.sv
// rtl/delay_timer_pkg.sv - shared types, defaults and step decision for delay_timer_mc
package delay_timer_pkg;

  localparam int CBITS_DEF     = 10;
  localparam int N_DEFAULT_DEF = 750;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STEP_INC = 2'd0,
    STEP_HIT = 2'd1,
    STEP_ERR = 2'd2
  } step_e;

  // Out-of-range beats terminal count, which beats a plain increment.
  function automatic step_e step_decide(input logic over, input logic hit);
    if (over) return STEP_ERR;
    if (hit) return STEP_HIT;
    return STEP_INC;
  endfunction

endpackage

// File: rtl/delay_timer_chan.sv
// rtl/delay_timer_chan.sv - one timer channel: FSM, counter, limit and sticky err
// Optional gate input enabled by DELAY_TIMER_GATE_EN.
module delay_timer_chan
  import delay_timer_pkg::*;
#(
  parameter int CBITS     = CBITS_DEF,
  parameter int N_DEFAULT = N_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             lim_we,
  input  logic [CBITS-1:0] lim_wdata,
  input  logic             err_clr,
`ifdef DELAY_TIMER_GATE_EN
  input  logic             gate,
`endif
  output logic             sig,
  output logic             err,
  output logic             flg,
  output logic             busy,
  output logic [CBITS-1:0] cnt
);

  state_e           state;
  logic [CBITS-1:0] limit;
  logic             gate_ok;

`ifdef DELAY_TIMER_GATE_EN
  assign gate_ok = gate;
`else
  assign gate_ok = 1'b1;
`endif

  assign flg  = (cnt <= limit);
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      limit <= CBITS'(N_DEFAULT);
      sig   <= 1'b0;
      err   <= 1'b0;
      state <= gate_ok ? RUN : IDLE;
    end else begin
      sig <= 1'b0;
      // Compare below still sees the old limit this cycle.
      if (lim_we) limit <= lim_wdata;
      // A same-cycle err set later in this block overrides the clear.
      if (err_clr) err <= 1'b0;
      if (start) begin
        cnt   <= '0;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (!gate_ok) begin
              state <= IDLE;
            end else if (en) begin
              case (step_decide(cnt > limit, cnt == limit))
                STEP_ERR: begin
                  cnt <= '0;
                  err <= 1'b1;
                end
                STEP_HIT: begin
                  cnt <= '0;
                  sig <= 1'b1;
                  if (mode) state <= DONE;
                end
                default: cnt <= cnt + 1'b1;
              endcase
            end
          end
          IDLE: if (gate_ok) state <= RUN;
          DONE: state <= DONE;
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: rtl/delay_timer_mc.sv
// rtl/delay_timer_mc.sv - multi-channel programmable delay timer top
// Optional gate input enabled by DELAY_TIMER_GATE_EN.
module delay_timer_mc
  import delay_timer_pkg::*;
#(
  parameter int CH        = 4,
  parameter int CBITS     = CBITS_DEF,
  parameter int N_DEFAULT = N_DEFAULT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       mode,
  input  logic [CH-1:0]       start,
  input  logic [CH-1:0]       lim_we,
  input  logic [CBITS-1:0]    lim_wdata,
  input  logic [CH-1:0]       err_clr,
`ifdef DELAY_TIMER_GATE_EN
  input  logic [CH-1:0]       gate,
`endif
  output logic [CH-1:0]       sig,
  output logic [CH-1:0]       err,
  output logic [CH-1:0]       flg,
  output logic [CH-1:0]       busy,
  output logic [CH*CBITS-1:0] cnt_o
);

  // The reset limit must fit in the counter, otherwise cnt could wrap.
  if (N_DEFAULT > (2**CBITS) - 1) begin : g_bad_default
    $error("N_DEFAULT does not fit in CBITS");
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    delay_timer_chan #(
      .CBITS     (CBITS),
      .N_DEFAULT (N_DEFAULT)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .mode      (mode[i]),
      .start     (start[i]),
      .lim_we    (lim_we[i]),
      .lim_wdata (lim_wdata),
      .err_clr   (err_clr[i]),
`ifdef DELAY_TIMER_GATE_EN
      .gate      (gate[i]),
`endif
      .sig       (sig[i]),
      .err       (err[i]),
      .flg       (flg[i]),
      .busy      (busy[i]),
      .cnt       (cnt_o[i*CBITS +: CBITS])
    );
  end

endmodule

// File: tb/tb_delay_timer_mc.sv
// tb/tb_delay_timer_mc.sv - scoreboard bench for delay_timer_mc with a reference model
module tb_delay_timer_mc;

  localparam int CH = 4;
  localparam int CB = 10;
  localparam int ND = 750;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   en = '0, mode = '0, start = '0, lim_we = '0, err_clr = '0;
  logic [CB-1:0]   lim_wdata = '0;
  logic [CH-1:0]   sig, err, flg, busy;
  logic [CH*CB-1:0] cnt_o;
`ifdef DELAY_TIMER_GATE_EN
  logic [CH-1:0]   gate = '1;
`endif

  delay_timer_mc #(.CH(CH), .CBITS(CB), .N_DEFAULT(ND)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
    .lim_we(lim_we), .lim_wdata(lim_wdata), .err_clr(err_clr),
`ifdef DELAY_TIMER_GATE_EN
    .gate(gate),
`endif
    .sig(sig), .err(err), .flg(flg), .busy(busy), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    sig, err, busy, flg;
    logic [CH*CB-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: channel is either counting (running) or parked after a one-shot.
  int m_cnt[CH], m_lim[CH];
  bit m_running[CH], m_err[CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sig",  64'(sig),   64'(e.sig));
      check("err",  64'(err),   64'(e.err));
      check("busy", 64'(busy),  64'(e.busy));
      check("flg",  64'(flg),   64'(e.flg));
      check("cnt",  64'(cnt_o), 64'(e.cnt));
    end
  end

  task automatic step(input logic r, input logic [CH-1:0] e_i, input logic [CH-1:0] m_i,
                      input logic [CH-1:0] s_i, input logic [CH-1:0] w_i,
                      input logic [CB-1:0] d_i, input logic [CH-1:0] c_i);
    exp_t x;
    @(negedge clk);
    rst = r; en = e_i; mode = m_i; start = s_i; lim_we = w_i; lim_wdata = d_i; err_clr = c_i;
    x = '0;
    for (int i = 0; i < CH; i++) begin
      bit pulse = 0;
      bit err_set = 0;
      if (r) begin
        m_cnt[i] = 0; m_lim[i] = ND; m_running[i] = 1; m_err[i] = 0;
      end else begin
        if (s_i[i]) begin
          m_cnt[i] = 0;
          m_running[i] = 1;
        end else if (m_running[i] && e_i[i]) begin
          if (m_cnt[i] > m_lim[i]) begin
            m_cnt[i] = 0; err_set = 1;
          end else if (m_cnt[i] == m_lim[i]) begin
            m_cnt[i] = 0; pulse = 1;
            if (m_i[i]) m_running[i] = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (err_set) m_err[i] = 1;
        else if (c_i[i]) m_err[i] = 0;
        if (w_i[i]) m_lim[i] = int'(d_i);
      end
      x.sig[i]  = pulse;
      x.err[i]  = m_err[i];
      x.busy[i] = m_running[i];
      x.flg[i]  = (m_cnt[i] <= m_lim[i]);
      x.cnt[i*CB +: CB] = CB'(m_cnt[i]);
    end
    exp_q.push_back(x);
  endtask

  task automatic idle_run(input int n, input logic [CH-1:0] e_i, input logic [CH-1:0] m_i);
    for (int k = 0; k < n; k++) step(0, e_i, m_i, '0, '0, '0, '0);
  endtask

  initial begin
    // Reset, then free-running periodic on the default limit: two pulses at 751-cycle spacing.
    step(1, '0, '0, '0, '0, '0, '0);
    step(1, '0, '0, '0, '0, '0, '0);
    idle_run(1600, '1, '0);

    // Lower the limit under a running count of 500 to provoke err, then clear it.
    step(1, '0, '0, '0, '0, '0, '0);
    idle_run(500, '1, '0);
    step(0, '1, '0, '0, '1, 10'd100, '0);
    idle_run(3, '1, '0);
    step(0, '1, '0, '0, '0, '0, 4'b0011);
    idle_run(3, '1, '0);
    step(0, '1, '0, '0, '1, 10'd0, '0);
    step(0, '1, '0, '0, '1, 10'd2, '0);
    step(0, '1, '0, '0, '0, '0, '1);

    // One-shot with limit 3, restarted once after it parks.
    step(0, '1, '1, '0, '1, 10'd3, '0);
    step(0, '1, '1, '1, '0, '0, '0);
    idle_run(10, '1, '1);
    step(0, '1, '1, '1, '0, '0, '0);
    idle_run(10, '1, '1);

    // Periodic limit 5 with en toggling every cycle.
    step(0, '1, '0, '1, '1, 10'd5, '0);
    for (int k = 0; k < 40; k++) step(0, (k % 2) ? '0 : '1, '0, '0, '0, '0, '0);

    // Limit 0: pulse every enabled cycle; a start on a terminal cycle suppresses it.
    step(0, '1, '0, '1, '1, 10'd0, '0);
    idle_run(6, '1, '0);
    step(0, '1, '0, 4'b0101, '0, '0, '0);
    idle_run(4, '1, '0);

    // Differing limits per channel, then reset mid-count.
    for (int i = 0; i < CH; i++) step(0, '1, '0, '0, CH'(1 << i), CB'(8 + 5 * i), '0);
    idle_run(30, '1, '0);
    step(1, '1, '0, '0, '0, '0, '0);
    idle_run(760, '1, '0);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [CH-1:0] e_r, m_r, s_r, w_r, c_r;
      logic [CB-1:0] d_r;
      for (int i = 0; i < CH; i++) begin
        e_r[i] = ($urandom_range(0, 3) != 0);
        m_r[i] = ($urandom_range(0, 3) == 0);
        s_r[i] = ($urandom_range(0, 40) == 0);
        w_r[i] = ($urandom_range(0, 40) == 0);
        c_r[i] = ($urandom_range(0, 20) == 0);
      end
      d_r = ($urandom_range(0, 9) == 0) ? CB'($urandom) : CB'($urandom_range(0, 30));
      step(($urandom_range(0, 999) == 0), e_r, m_r, s_r, w_r, d_r, c_r);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_timer_mc.md
Name: delay_timer_mc

Overview:
- Multi-channel, runtime-programmable successor to the single fixed-period delay counter.
- Each channel counts enabled cycles and emits a one-cycle `sig` pulse when its count reaches a programmable limit.
- Each channel runs periodic or one-shot, and raises a sticky `err` on an out-of-range count.
- Sits beside the control block as the shared timebase/timeout generator for downstream sequencers.

Parameters:
- CH, 4, number of independent channels.
- CBITS, 10, counter and limit width.
- N_DEFAULT, 750, per-channel limit after reset; elaboration check N_DEFAULT <= 2**CBITS-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  CH  per-channel count enable; 0 freezes the counter.
- mode  in  CH  0 = periodic, 1 = one-shot; sampled every cycle.
- start  in  CH  restart strobe.
- lim_we  in  CH  limit write strobe.
- lim_wdata  in  CBITS  shared limit write data.
- err_clr  in  CH  clears sticky err.
- sig  out  CH  one-cycle terminal pulse, registered.
- err  out  CH  sticky out-of-range flag, registered.
- flg  out  CH  in-range indicator, combinational: cnt <= limit.
- busy  out  CH  channel in RUN.
- cnt_o  out  CH*CBITS  counters, channel i at [i*CBITS +: CBITS].

Behaviour:
- Reset (rst=1 at posedge; overrides all inputs):
  - cnt=0, limit=N_DEFAULT, state=RUN.
  - sig=0, err=0; hence flg=1, busy=1.
- Per-channel FSM with states IDLE, RUN, DONE. IDLE is entered only via the optional feature gate below; otherwise it is unreachable but encoded.
- RUN with en=1, in priority order:
  - cnt > limit (possible only after a limit write): cnt<=0, err<=1, sig<=0.
  - cnt == limit: cnt<=0, sig<=1; if mode=1, go to DONE.
  - Otherwise: cnt<=cnt+1, sig<=0.
- Timing:
  - Periodic period = limit+1 cycles.
  - limit=0 gives sig=1 every enabled cycle.
  - First pulse after reset appears on the posedge that is N_DEFAULT+1 enabled cycles after rst deasserts.
- RUN with en=0: cnt and state hold, sig<=0.
- DONE:
  - cnt holds 0, sig<=0, busy=0.
  - start moves to RUN with cnt=0.
  - en has no effect.
- start in RUN or IDLE: cnt<=0, state<=RUN, sig<=0. start has priority over the terminal and err checks in the same cycle.
- lim_we:
  - limit<=lim_wdata at the posedge.
  - Same-cycle compare uses the old limit; the new value applies from the next cycle.
  - The counter is not cleared. Lowering the limit below cnt yields err on the next enabled RUN cycle.
- err:
  - Set has priority over err_clr in the same cycle.
  - err_clr alone gives err<=0 next cycle.
- Overflow: cnt never exceeds 2**CBITS-1, because cnt <= limit <= 2**CBITS-1. No wrap-around is possible.
- Channels are fully independent; lim_wdata may be written to several channels at once.

Optional Feature:
- Macro: DELAY_TIMER_GATE_EN.
- Defined:
  - Extra input `gate [CH]`.
  - gate=0 in RUN moves to IDLE (cnt holds, busy=0); gate=1 in IDLE returns to RUN at the held cnt.
  - Reset state becomes IDLE if gate=0 during reset.
- Undefined: no gate port; IDLE is never entered.

Decomposition:
- Package delay_timer_pkg:
  - `state_e` enum {IDLE, RUN, DONE}.
  - Localparam defaults for CBITS and N_DEFAULT.
  - Helper function for the next-cnt/sig decision.
- One sub-module, delay_timer_chan: a single channel (FSM, cnt, limit, err).
- delay_timer_mc generates CH instances and flattens cnt_o.

Test Plan:
- Reset, then en=1, mode=0 on channel 0 (limit 750) -> sig[0] pulses every 751 cycles, first pulse 751 cycles after reset; flg=1 and err=0 throughout.
- Write limit=3 with mode=1, then start -> sig pulses once 4 cycles after start, then busy=0 and cnt_o=0; a later start gives one more pulse.
- cnt=500 on limit 750, write lim_wdata=100 -> next cycle flg=0; following cycle err=1, cnt=0, no sig. err_clr drops err; err_clr asserted together with a new err keeps err=1.
- Periodic limit=5, en toggled 1/0 every cycle -> period stretches to 12 cycles and sig never asserts while en=0.
- Limit=0, mode=0 -> sig=1 continuously; start asserted on the terminal cycle -> sig=0 that cycle.
- rst asserted mid-count on all channels with differing limits -> all cnt=0 and limits=750 the next cycle; periodic schedule restarts.
